// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and a
// synchronous instruction memory.
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : fetch address, stable while imem_req=1
//   imem_ack   : response valid, completes the outstanding request
//   imem_rdata : 16-bit instruction, valid with imem_ack
// master = fetch stage, slave = memory.
interface if_stage_if #(
  parameter int unsigned PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage feeding the decode stage's IF/ID register.
// Keeps the PC, issues one instruction-memory request at a time, buffers the
// returned words with their PCs in a small prefetch FIFO and presents the FIFO
// head downstream, honouring stall and branch redirect.
//
// Ports:
//   clk                : clock, all state on rising edge
//   rst                : asynchronous active-low reset
//   stall              : downstream not accepting, head is held
//   branch_taken       : one-cycle redirect pulse
//   branch_target      : redirect address, valid with branch_taken
//   imem               : instruction-memory bus (if_stage_if.master)
//   instruction_output : FIFO head instruction, NOP_INSTR when empty
//   pc_output          : PC of FIFO head, 0 when empty
//   instr_valid        : FIFO head valid
//   halted             : fetch halted on a halt opcode
//
// Optional feature: define FETCH_HALT_EN to stop fetching after a pushed
// instruction whose opcode [15:11] equals HALT_OPCODE. Without it, halted is
// constant 0 and the halt opcode is fetched like any other instruction.
module if_stage #(
  parameter int unsigned     PC_W        = 8,
  parameter int unsigned     FIFO_DEPTH  = 2,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [15:0]     NOP_INSTR   = 16'h0000,
  parameter logic [4:0]      HALT_OPCODE = 5'b11111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  if_stage_if.master      imem,
  output logic [15:0]     instruction_output,
  output logic [PC_W-1:0] pc_output,
  output logic            instr_valid,
  output logic            halted
);

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_addr;
  logic            r_req;
  logic            r_halted;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  entry_t          r_mem [FIFO_DEPTH];
  entry_t          r_head;
  logic            r_valid;

  state_t           w_state_nxt;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [PC_W-1:0]  w_addr_nxt;
  logic             w_halted_nxt;
  logic [PTR_W-1:0] w_wptr_nxt;
  logic [PTR_W-1:0] w_rptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  entry_t           w_head_nxt;
  entry_t           w_push_entry;
  logic             w_push;
  logic             w_pop;
  logic             w_halt_hit;

  // Only an ack to a live (non-flushed) request is buffered; redirect wins.
  assign w_push       = (r_state == S_REQ) && imem.imem_ack && !branch_taken;
  assign w_pop        = r_valid && !stall && !branch_taken;
  assign w_push_entry = '{instr: imem.imem_rdata, pc: r_pc};
  assign w_halt_hit   = HALT_EN && w_push && (imem.imem_rdata[15:11] == HALT_OPCODE);

  // Next-state, PC, FIFO bookkeeping and registered-head lookahead.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_halted_nxt = r_halted | w_halt_hit;
    w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_rptr_nxt   = w_pop  ? r_rptr + PTR_W'(1) : r_rptr;
    w_wptr_nxt   = w_push ? r_wptr + PTR_W'(1) : r_wptr;
    if (w_push) begin
      w_pc_nxt = r_pc + PC_W'(1);
    end

    if (branch_taken) begin
      w_count_nxt  = '0;
      w_rptr_nxt   = '0;
      w_wptr_nxt   = '0;
      w_pc_nxt     = branch_target;
      w_halted_nxt = 1'b0;
      // An unacked outstanding request must still be drained before refetch.
      w_state_nxt  = ((r_state != S_IDLE) && !imem.imem_ack) ? S_FLUSH : S_REQ;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if ((r_count < CNT_W'(FIFO_DEPTH)) && !r_halted) begin
            w_state_nxt = S_REQ;
          end
        end
        S_REQ: begin
          if (imem.imem_ack) begin
            w_state_nxt = ((w_count_nxt < CNT_W'(FIFO_DEPTH)) && !w_halted_nxt) ? S_REQ : S_IDLE;
          end
        end
        S_FLUSH: begin
          if (imem.imem_ack) begin
            w_state_nxt = S_REQ;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // New address only when a fresh request starts; held otherwise (incl. flush).
    w_addr_nxt = (w_state_nxt == S_REQ) ? w_pc_nxt : r_addr;

    // Head after this edge: the word being pushed lands at the head only when
    // the FIFO is otherwise empty, which is exactly when wptr meets next rptr.
    w_head_nxt = '{instr: NOP_INSTR, pc: PC_W'(0)};
    if (w_count_nxt != '0) begin
      if (w_push && (r_wptr == w_rptr_nxt)) begin
        w_head_nxt = w_push_entry;
      end else begin
        w_head_nxt = r_mem[w_rptr_nxt];
      end
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_addr   <= RESET_PC;
      r_req    <= 1'b0;
      r_halted <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_head   <= '{instr: NOP_INSTR, pc: PC_W'(0)};
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_addr   <= w_addr_nxt;
      r_req    <= (w_state_nxt != S_IDLE);
      r_halted <= w_halted_nxt;
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_count  <= w_count_nxt;
      r_head   <= w_head_nxt;
      r_valid  <= (w_count_nxt != '0);
    end
  end

  // Prefetch storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_entry;
    end
  end

  assign imem.imem_req      = r_req;
  assign imem.imem_addr     = r_addr;
  assign instruction_output = r_head.instr;
  assign pc_output          = r_head.pc;
  assign instr_valid        = r_valid;
  assign halted             = r_halted;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: random-latency memory responder, random
// stall/redirect stimulus, and a scoreboard of the expected instruction stream.
module tb_if_stage;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned DEPTH  = 2;
  localparam logic [7:0]  RST_PC = 8'h00;
  localparam logic [15:0] NOP    = 16'h0000;

  typedef struct packed {
    logic [15:0] instr;
    logic [7:0]  pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic [15:0] instruction_output;
  logic [7:0]  pc_output;
  logic        instr_valid;
  logic        halted;

  if_stage_if #(.PC_W(PC_W)) imem ();

  if_stage #(
    .PC_W(PC_W), .FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC),
    .NOP_INSTR(NOP), .HALT_OPCODE(5'b11111)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem(imem),
    .instruction_output(instruction_output), .pc_output(pc_output),
    .instr_valid(instr_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pops  = 0;
  int          lat_max = 0;
  int          lat     = -1;
  int          epoch   = 0;
  int          req_epoch = 0;
  bit          ack_fire = 1'b0;
  bit          model_halted = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [7:0]  model_pc = RST_PC;

  bit          prev_ok = 1'b0;
  bit          prev_branch = 1'b0;
  bit          prev_req = 1'b0;
  bit          prev_halted = 1'b0;
  int          prev_size = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    model_pc     = RST_PC;
    model_halted = 1'b0;
    epoch++;
  endtask

  // Memory responder: random wait per request, checks address stability.
  initial begin
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst || !imem.imem_req) begin
        imem.imem_ack = 1'b0;
        ack_fire      = 1'b0;
        lat           = -1;
      end else begin
        if (lat < 0) begin
          lat       = int'($urandom_range(32'(lat_max)));
          req_addr  = imem.imem_addr;
          req_epoch = epoch;
`ifdef FETCH_HALT_EN
          chk("req_while_halted", 32'(model_halted), 32'd0);
`endif
        end else begin
          chk("addr_stable", 32'(imem.imem_addr), 32'(req_addr));
        end
        if (lat == 0) begin
          imem.imem_ack   = 1'b1;
          imem.imem_rdata = mem[imem.imem_addr];
          ack_fire        = 1'b1;
          lat             = -1;
        end else begin
          imem.imem_ack   = 1'b0;
          imem.imem_rdata = 16'($urandom);
          ack_fire        = 1'b0;
          lat--;
        end
      end
    end
  end

  // Reference model: in-order stream of mem[pc], pc from the last redirect.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        if (branch_taken) begin
          sb_q.delete();
          model_pc     = branch_target;
          model_halted = 1'b0;
          epoch++;
        end else if (ack_fire && (req_epoch == epoch)) begin
          chk("fetch_addr", 32'(req_addr), 32'(model_pc));
          sb_q.push_back('{instr: mem[model_pc], pc: model_pc});
`ifdef FETCH_HALT_EN
          if (mem[model_pc][15:11] == 5'b11111) model_halted = 1'b1;
`endif
          model_pc = model_pc + 8'd1;
        end
      end
    end
  end

  // Monitor: compares the presented head and pops on consumption.
  initial begin
    bit exp_valid;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        prev_ok = 1'b0;
      end else begin
        exp_valid = (sb_q.size() != 0);
        chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (instr_valid && exp_valid) begin
          chk("head_instr", 32'(instruction_output), 32'(sb_q[0].instr));
          chk("head_pc", 32'(pc_output), 32'(sb_q[0].pc));
        end else if (!instr_valid) begin
          chk("empty_instr", 32'(instruction_output), 32'(NOP));
          chk("empty_pc", 32'(pc_output), 32'd0);
        end
        chk("halted", 32'(halted), 32'(model_halted));
        if (sb_q.size() == DEPTH) chk("full_noreq", 32'(imem.imem_req), 32'd0);
        if (prev_ok && (prev_branch || (!prev_req && prev_size < DEPTH && !prev_halted)))
          chk("req_issue", 32'(imem.imem_req), 32'd1);
        prev_ok     = 1'b1;
        prev_branch = branch_taken;
        prev_req    = imem.imem_req;
        prev_size   = sb_q.size();
        prev_halted = model_halted;
        if (instr_valid && exp_valid && !stall && !branch_taken) begin
          void'(sb_q.pop_front());
          n_pops++;
        end
      end
    end
  end

  // Random stall/redirect for a number of cycles.
  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      stall        = ($urandom_range(3) == 0);
      branch_taken = ($urandom_range(15) == 0);
      case ($urandom_range(3))
        0:       branch_target = 8'hFF;
        1:       branch_target = 8'hFE;
        default: branch_target = 8'($urandom);
      endcase
    end
    @(negedge clk);
    branch_taken = 1'b0;
    stall        = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[3] = 16'hF800;

    // Reset values.
    repeat (3) @(negedge clk);
    #2;
    chk("rst_req", 32'(imem.imem_req), 32'd0);
    chk("rst_addr", 32'(imem.imem_addr), 32'(RST_PC));
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instruction_output), 32'(NOP));
    chk("rst_pc", 32'(pc_output), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // Streaming with zero-wait memory.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("first_req", 32'(imem.imem_req), 32'd1);
    chk("first_addr", 32'(imem.imem_addr), 32'(RST_PC));
    @(negedge clk);
    #2;
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_pc", 32'(pc_output), 32'(RST_PC));
    chk("second_addr", 32'(imem.imem_addr), 32'(RST_PC + 8'd1));
    repeat (8) @(negedge clk);
`ifdef FETCH_HALT_EN
    #2;
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_noreq", 32'(imem.imem_req), 32'd0);
`endif
    branch_taken  = 1'b1;
    branch_target = 8'h00;
    @(negedge clk);
    branch_taken = 1'b0;
    #2;
    chk("redirect_halt_clr", 32'(halted), 32'd0);

    // Stall with full FIFO.
    stall = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    chk("stall_noreq", 32'(imem.imem_req), 32'd0);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    chk("stall_head", 32'(pc_output), 32'd0);
    @(negedge clk);
    stall = 1'b0;
    repeat (4) @(negedge clk);

    // Random phase with variable memory latency.
    lat_max = 3;
    random_phase(1500);

    // Reset asserted while a request is pending.
    for (int k = 0; k < 40 && !imem.imem_req; k++) @(negedge clk);
    chk("req_seen", 32'(imem.imem_req), 32'd1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_rst_req", 32'(imem.imem_req), 32'd0);
    chk("async_rst_valid", 32'(instr_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    random_phase(1500);
    repeat (5) @(negedge clk);
    chk("progress", 32'(n_pops > 200), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
